// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a valid/ready handshake and a two-entry skid buffer.
// Supports hazard stall, branch flush with selectable priority, and saturating event counters.
module if_id_skid_reg #(
    parameter int                 INSTR_W    = 32,
    parameter int                 PC_W       = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR  = 32'h0000_0013,
    parameter bit                 FLUSH_PRIO = 1'b1,
    parameter int                 CNT_W      = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    input  logic               stall,
    input  logic               flush,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    logic               m_valid, m_valid_d;
    logic [INSTR_W-1:0] m_instr, m_instr_d;
    logic [PC_W-1:0]    m_pc, m_pc_d;
    logic               s_valid, s_valid_d;
    logic [INSTR_W-1:0] s_instr, s_instr_d;
    logic [PC_W-1:0]    s_pc, s_pc_d;
    logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;

    logic accept;
    logic emit;
    logic eff_flush;
    logic stall_event;

    // in_ready depends only on the skid register, so there is no path from decode back to fetch.
    assign accept      = in_valid & ~s_valid;
    assign emit        = m_valid & out_ready & ~stall;
    assign eff_flush   = flush & (FLUSH_PRIO | ~stall);
    assign stall_event = stall & m_valid;

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no latch can be inferred.
        m_valid_d = m_valid;
        m_instr_d = m_instr;
        m_pc_d    = m_pc;
        s_valid_d = s_valid;
        s_instr_d = s_instr;
        s_pc_d    = s_pc;

        if (eff_flush) begin
            m_valid_d = 1'b0;
            m_instr_d = NOP_INSTR;
            s_valid_d = 1'b0;
        end else if (!m_valid || emit) begin
            if (s_valid) begin
                m_valid_d = 1'b1;
                m_instr_d = s_instr;
                m_pc_d    = s_pc;
                s_valid_d = accept;
                if (accept) begin
                    s_instr_d = in_instr;
                    s_pc_d    = in_pc;
                end
            end else begin
                m_valid_d = accept;
                if (accept) begin
                    m_instr_d = in_instr;
                    m_pc_d    = in_pc;
                end
            end
        end else if (accept) begin
            // Main is held and skid is necessarily empty here, since accept needs in_ready.
            s_valid_d = 1'b1;
            s_instr_d = in_instr;
            s_pc_d    = in_pc;
        end
    end

    // NOTE: the payload registers are reset too; there are only two entries, and a known
    // value keeps out_instr/out_pc deterministic out of reset without relying on the valid mux.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            m_valid <= 1'b0;
            m_instr <= NOP_INSTR;
            m_pc    <= '0;
            s_valid <= 1'b0;
            s_instr <= NOP_INSTR;
            s_pc    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            m_valid <= m_valid_d;
            m_instr <= m_instr_d;
            m_pc    <= m_pc_d;
            s_valid <= s_valid_d;
            s_instr <= s_instr_d;
            s_pc    <= s_pc_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_event && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (eff_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign in_ready  = ~s_valid;
    assign out_valid = m_valid;
    assign out_instr = m_valid ? m_instr : NOP_INSTR;
    assign out_pc    = m_valid ? m_pc : '0;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed bench for if_id_skid_reg: default instance on a scoreboard, plus a
// FLUSH_PRIO=0 / CNT_W=4 instance for priority and saturation behaviour.
module tb_if_id_skid_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    logic        in_valid, in_ready, out_valid, out_ready, stall, flush;
    logic [31:0] in_instr, in_pc, out_instr, out_pc;
    logic [15:0] stall_cnt, flush_cnt;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_stall, b_flush;
    logic [31:0] b_in_instr, b_in_pc, b_out_instr, b_out_pc;
    logic [3:0]  b_stall_cnt, b_flush_cnt;

    if_id_skid_reg dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .stall(stall), .flush(flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    if_id_skid_reg #(.FLUSH_PRIO(1'b0), .CNT_W(4)) dut_b (
        .i_clk(i_clk), .i_rst(i_rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_instr(b_out_instr), .out_pc(b_out_pc),
        .stall(b_stall), .flush(b_flush), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    entry_t sb_q[$];
    int     passed = 0;
    int     total  = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'hC0DE_0000 ^ pc;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Present an entry that the bench expects to be accepted this cycle.
    task automatic send(input logic [31:0] pc);
        entry_t e;
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr_of(pc);
        e.pc     = pc;
        e.instr  = instr_of(pc);
        sb_q.push_back(e);
    endtask

    // Present an entry that must not be accepted (backpressure or flush).
    task automatic present(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr_of(pc);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_pc    = '0;
        in_instr = '0;
    endtask

    // Outputs are sampled 1 time unit after a rising edge; an emit this cycle pops the scoreboard.
    task automatic tick();
        entry_t e;
        if (out_valid && out_ready && !stall) begin
            if (sb_q.size() == 0) begin
                check("unexpected_emit", 64'(out_pc), 64'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("sb_pc", 64'(out_pc), 64'(e.pc));
                check("sb_instr", 64'(out_instr), 64'(e.instr));
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst = 1'b0;
        idle();
        out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
        b_in_valid = 1'b0; b_in_pc = '0; b_in_instr = '0;
        b_out_ready = 1'b0; b_stall = 1'b0; b_flush = 1'b0;

        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'(NOP));
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        check("rst_flush_cnt", 64'(flush_cnt), 64'd0);
        #11 i_rst = 1'b1;
        @(posedge i_clk);
        #1;

        // Streaming at full rate.
        out_ready = 1'b1;
        send(32'h00); tick();
        check("stream_valid0", 64'(out_valid), 64'd1);
        check("stream_ready0", 64'(in_ready), 64'd1);
        send(32'h04); tick();
        check("stream_ready1", 64'(in_ready), 64'd1);
        send(32'h08); tick();
        check("stream_ready2", 64'(in_ready), 64'd1);
        idle(); tick();
        tick();
        check("stream_drained", 64'(out_valid), 64'd0);
        check("stream_stall_cnt", 64'(stall_cnt), 64'd0);

        // Stall absorb: 0x14 lands in skid, 0x18 waits for in_ready.
        send(32'h10); tick();
        stall = 1'b1;
        send(32'h14); tick();
        check("absorb_ready_drop", 64'(in_ready), 64'd0);
        check("absorb_hold_pc", 64'(out_pc), 64'h10);
        present(32'h18); tick();
        check("absorb_ready_low1", 64'(in_ready), 64'd0);
        tick();
        check("absorb_ready_low2", 64'(in_ready), 64'd0);
        check("absorb_stall_cnt", 64'(stall_cnt), 64'd3);
        stall = 1'b0;
        tick();
        check("absorb_ready_rise", 64'(in_ready), 64'd1);
        check("absorb_skid_to_main", 64'(out_pc), 64'h14);
        send(32'h18); tick();
        idle(); tick();
        check("absorb_stall_cnt_end", 64'(stall_cnt), 64'd3);

        // Flush with both entries occupied; 0x28 is offered but never appears.
        out_ready = 1'b0;
        send(32'h20); tick();
        send(32'h24); tick();
        check("flush_full_ready", 64'(in_ready), 64'd0);
        present(32'h28);
        flush = 1'b1;
        sb_q.delete();
        tick();
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_out_instr", 64'(out_instr), 64'(NOP));
        check("flush_out_pc", 64'(out_pc), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_cnt_1", 64'(flush_cnt), 64'd1);
        // A flush drops an entry accepted in the same cycle.
        out_ready = 1'b1;
        present(32'h2C); tick();
        flush = 1'b0;
        idle();
        check("flush_drop_valid", 64'(out_valid), 64'd0);
        check("flush_cnt_2", 64'(flush_cnt), 64'd2);
        tick();
        check("flush_drop_stays", 64'(out_valid), 64'd0);

        // Priority with FLUSH_PRIO=1: flush wins over stall.
        send(32'h30); tick();
        idle();
        stall = 1'b1; flush = 1'b1;
        void'(sb_q.pop_front());
        tick();
        stall = 1'b0; flush = 1'b0;
        check("prio1_out_valid", 64'(out_valid), 64'd0);
        check("prio1_flush_cnt", 64'(flush_cnt), 64'd3);
        check("prio1_stall_cnt", 64'(stall_cnt), 64'd4);

        // Priority with FLUSH_PRIO=0 and 4-bit counter saturation on the second instance.
        b_in_valid = 1'b1; b_in_pc = 32'h30; b_in_instr = instr_of(32'h30);
        tick();
        b_in_valid = 1'b0;
        b_stall = 1'b1; b_flush = 1'b1;
        tick();
        check("prio0_out_valid", 64'(b_out_valid), 64'd1);
        check("prio0_out_pc", 64'(b_out_pc), 64'h30);
        check("prio0_flush_cnt", 64'(b_flush_cnt), 64'd0);
        check("prio0_stall_cnt", 64'(b_stall_cnt), 64'd1);
        b_flush = 1'b0;
        repeat (13) tick();
        check("sat_below", 64'(b_stall_cnt), 64'd14);
        repeat (6) tick();
        check("sat_max", 64'(b_stall_cnt), 64'd15);
        repeat (3) tick();
        check("sat_hold", 64'(b_stall_cnt), 64'd15);
        b_stall = 1'b0; b_flush = 1'b1;
        tick();
        b_flush = 1'b0;
        check("prio0_flush_ok", 64'(b_out_valid), 64'd0);
        check("prio0_flush_instr", 64'(b_out_instr), 64'(NOP));
        check("prio0_flush_cnt_1", 64'(b_flush_cnt), 64'd1);

        // Asynchronous reset with both entries occupied, checked before the next edge.
        out_ready = 1'b0;
        send(32'h40); tick();
        send(32'h44); tick();
        idle();
        check("arst_pre_ready", 64'(in_ready), 64'd0);
        #2 i_rst = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_instr", 64'(out_instr), 64'(NOP));
        check("arst_out_pc", 64'(out_pc), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_stall_cnt", 64'(stall_cnt), 64'd0);
        check("arst_flush_cnt", 64'(flush_cnt), 64'd0);
        check("arst_b_stall_cnt", 64'(b_stall_cnt), 64'd0);
        sb_q.delete();
        #1 i_rst = 1'b1;
        @(posedge i_clk);
        #1;

        // Traffic resumes after reset.
        out_ready = 1'b1;
        send(32'h50); tick();
        idle(); tick();
        check("post_rst_idle", 64'(out_valid), 64'd0);
        check("sb_empty_end", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
